// File: rtl/motion_event_ctrl.sv
// PIR motion path: synchronize and debounce the sensor line, mask sensor warm-up,
// run the idle/motion/hold detector and keep a saturating 4-digit BCD event count.
module motion_event_ctrl #(
  parameter int WARMUP_CYCLES   = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 200_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        motion_in,
  input  logic        arm,
  input  logic        clear_count,
  output logic        state_motion,
  output logic        state_stable,
  output logic        warming,
  output logic        motion_pulse,
  output logic [15:0] sseg_value
);

  localparam int WW = $clog2(WARMUP_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_IDLE   = 2'd1,
    ST_MOTION = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync2_q, filt_q, filt_prev_q;
  logic [DW-1:0]   db_cnt_q;
  logic [WW-1:0]   warm_cnt_q;
  logic [HW-1:0]   hold_cnt_q;
  logic [15:0]     count_q, count_d, count_inc;
  logic            event_d, filt_rise, carry;
  logic            warming_q, motion_q, stable_q, pulse_q;

  // The stability counter runs only while the synchronized level disagrees with
  // the filtered level; the last count step and the level update share an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      db_cnt_q    <= '0;
    end else begin
      sync1_q     <= motion_in;
      sync2_q     <= sync1_q;
      filt_prev_q <= filt_q;
      if (sync2_q == filt_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        filt_q   <= sync2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DW'(1);
      end
    end
  end

  assign filt_rise = filt_q & ~filt_prev_q;

  always_comb begin
    state_d = state_q;
    event_d = 1'b0;
    case (state_q)
      ST_WARMUP: if (warm_cnt_q == WW'(WARMUP_CYCLES)) state_d = ST_IDLE;
      ST_IDLE: begin
        if (filt_rise && arm) begin
          state_d = ST_MOTION;
          event_d = 1'b1;
        end
      end
      ST_MOTION: begin
        if (!arm)         state_d = ST_IDLE;
        else if (!filt_q) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!arm)                  state_d = ST_IDLE;
        else if (filt_rise)        state_d = ST_MOTION;
        else if (hold_cnt_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_WARMUP;
    endcase
  end

  // BCD increment with per-digit carry; 9999 is held rather than wrapped.
  always_comb begin
    count_inc = count_q;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count_inc[i*4 +: 4] == 4'd9) begin
          count_inc[i*4 +: 4] = 4'd0;
        end else begin
          count_inc[i*4 +: 4] = count_inc[i*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (clear_count)                         count_d = '0;
    else if (event_d && count_q != 16'h9999) count_d = count_inc;
    else                                     count_d = count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_WARMUP;
      warm_cnt_q <= '0;
      hold_cnt_q <= '0;
      count_q    <= '0;
      pulse_q    <= 1'b0;
      warming_q  <= 1'b1;
      motion_q   <= 1'b0;
      stable_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pulse_q   <= event_d;
      warming_q <= (state_d == ST_WARMUP);
      motion_q  <= (state_d == ST_MOTION) || (state_d == ST_HOLD);
      stable_q  <= (state_d == ST_IDLE);
      if (state_q == ST_WARMUP && state_d == ST_WARMUP) warm_cnt_q <= warm_cnt_q + WW'(1);
      if (state_q == ST_MOTION && state_d == ST_HOLD) begin
        hold_cnt_q <= HW'(HOLD_CYCLES - 1);
      end else if (state_q == ST_HOLD && hold_cnt_q != '0) begin
        hold_cnt_q <= hold_cnt_q - HW'(1);
      end
    end
  end

  assign warming      = warming_q;
  assign state_motion = motion_q;
  assign state_stable = stable_q;
  assign motion_pulse = pulse_q;
  assign sseg_value   = count_q;

endmodule

// File: tb/tb_motion_event_ctrl.sv
// Bench for motion_event_ctrl: main instance with short timing, plus a fast
// instance used to sweep the BCD count up to saturation.
module tb_motion_event_ctrl;

  localparam int W = 20;
  localparam int D = 4;
  localparam int H = 10;

  logic        clk;
  logic        reset, motion_in, arm, clear_count;
  logic        state_motion, state_stable, warming, motion_pulse;
  logic [15:0] sseg_value;

  logic        reset_f, motion_f, arm_f, clear_f;
  logic        sm_f, ss_f, warm_f, pulse_f;
  logic [15:0] sseg_f;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n;

  typedef struct {
    int          e;
    logic [15:0] v;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        got;
  logic [15:0] fq[$];
  logic [15:0] f_exp;
  logic [15:0] f_last[3];
  logic [15:0] f_bad_act, f_bad_req;
  int          f_bad    = 0;
  int          f_pulses = 0;

  motion_event_ctrl #(.WARMUP_CYCLES(W), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) u_dut (
    .clk(clk), .reset(reset), .motion_in(motion_in), .arm(arm), .clear_count(clear_count),
    .state_motion(state_motion), .state_stable(state_stable), .warming(warming),
    .motion_pulse(motion_pulse), .sseg_value(sseg_value)
  );

  motion_event_ctrl #(.WARMUP_CYCLES(2), .DEBOUNCE_CYCLES(1), .HOLD_CYCLES(1)) u_fast (
    .clk(clk), .reset(reset_f), .motion_in(motion_f), .arm(arm_f), .clear_count(clear_f),
    .state_motion(sm_f), .state_stable(ss_f), .warming(warm_f),
    .motion_pulse(pulse_f), .sseg_value(sseg_f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge index relative to reset release: after edge e is sampled, edge_n == e.
  always @(posedge clk or posedge reset) begin
    if (reset) edge_n <= -1;
    else       edge_n <= edge_n + 1;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (exp_q.size() > 0 && exp_q[0].e < edge_n) begin
        n_checks++;
        got = exp_q.pop_front();
        $display("FAIL missed_pulse: no motion_pulse seen, required at edge %0d (now %0d)", got.e, edge_n);
      end
      if (motion_pulse === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_pulse: pulse at edge %0d sseg=%h, required no pulse", edge_n, sseg_value);
        end else begin
          got = exp_q.pop_front();
          if (got.e != edge_n || sseg_value !== got.v)
            $display("FAIL event_pulse: edge %0d sseg=%h, required edge %0d sseg=%h", edge_n, sseg_value, got.e, got.v);
          else
            n_pass++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_f && pulse_f === 1'b1) begin
      f_pulses++;
      f_last[0] = f_last[1];
      f_last[1] = f_last[2];
      f_last[2] = sseg_f;
      if (fq.size() == 0) begin
        if (f_bad == 0) begin f_bad_act = sseg_f; f_bad_req = 16'hxxxx; end
        f_bad++;
      end else begin
        f_exp = fq.pop_front();
        if (sseg_f !== f_exp) begin
          if (f_bad == 0) begin f_bad_act = sseg_f; f_bad_req = f_exp; end
          f_bad++;
        end
      end
    end
  end

  function automatic logic [15:0] to_bcd(input int n);
    int m;
    m = (n > 9999) ? 9999 : n;
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic wait_edge(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic push_event(input int e, input logic [15:0] v);
    exp_t x;
    x.e = e;
    x.v = v;
    exp_q.push_back(x);
  endtask

  task automatic test_reset;
    int bad;
    reset = 1'b1; reset_f = 1'b1;
    motion_in = 1'b1; arm = 1'b1; clear_count = 1'b0;
    motion_f = 1'b0; arm_f = 1'b1; clear_f = 1'b0;
    @(posedge clk); #2;
    n_checks++;
    if ({warming, state_motion, state_stable, motion_pulse, sseg_value} !== {4'b1000, 16'h0000})
      $display("FAIL reset_vals: w/m/s/p=%b%b%b%b sseg=%h, required 1000 0000",
               warming, state_motion, state_stable, motion_pulse, sseg_value);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0; reset_f = 1'b0;
    bad = 0;
    for (int e = 0; e < W; e++) begin
      wait_edge(e);
      if (warming !== 1'b1 || state_stable !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL warmup_window: %0d cycles left warm-up early, required 0", bad);
    else n_pass++;
    wait_edge(W);
    n_checks++;
    if (warming !== 1'b0 || state_stable !== 1'b1)
      $display("FAIL warmup_exit: warming=%b stable=%b at edge %0d, required 0 1", warming, state_stable, edge_n);
    else n_pass++;
    wait_edge(W + 10);
    n_checks++;
    if (sseg_value !== 16'h0000 || state_stable !== 1'b1)
      $display("FAIL high_at_idle_entry: sseg=%h stable=%b, required 0000 1", sseg_value, state_stable);
    else n_pass++;
    motion_in = 1'b0;
    wait_edge(edge_n + 8);
  endtask

  task automatic test_detect;
    int k;
    k = edge_n + 1;
    motion_in = 1'b1;
    push_event(k + 6, 16'h0001);
    wait_edge(k + 5);
    n_checks++;
    if (state_motion !== 1'b0 || state_stable !== 1'b1)
      $display("FAIL pre_detect: motion=%b stable=%b at k+5, required 0 1", state_motion, state_stable);
    else n_pass++;
    wait_edge(k + 6);
    n_checks++;
    if (state_motion !== 1'b1 || state_stable !== 1'b0 || sseg_value !== 16'h0001)
      $display("FAIL detect: motion=%b stable=%b sseg=%h at k+6, required 1 0 0001",
               state_motion, state_stable, sseg_value);
    else n_pass++;
    wait_edge(k + 7);
    n_checks++;
    if (motion_pulse !== 1'b0) $display("FAIL pulse_width: pulse=%b at k+7, required 0", motion_pulse);
    else n_pass++;
  endtask

  task automatic test_retrigger;
    int t, t2;
    t = edge_n + 1 + 6;
    motion_in = 1'b0;
    wait_edge(t - 1);
    motion_in = 1'b1;
    wait_edge(t);
    n_checks++;
    if (state_motion !== 1'b1 || state_stable !== 1'b0)
      $display("FAIL hold_entry: motion=%b stable=%b, required 1 0", state_motion, state_stable);
    else n_pass++;
    wait_edge(t + 12);
    n_checks++;
    if (state_motion !== 1'b1 || state_stable !== 1'b0 || sseg_value !== 16'h0001)
      $display("FAIL retrigger: motion=%b stable=%b sseg=%h past hold expiry, required 1 0 0001",
               state_motion, state_stable, sseg_value);
    else n_pass++;
    t2 = edge_n + 1 + 6;
    motion_in = 1'b0;
    wait_edge(t2 + H - 1);
    n_checks++;
    if (state_motion !== 1'b1 || state_stable !== 1'b0)
      $display("FAIL hold_before_expiry: motion=%b stable=%b, required 1 0", state_motion, state_stable);
    else n_pass++;
    wait_edge(t2 + H);
    n_checks++;
    if (state_motion !== 1'b0 || state_stable !== 1'b1)
      $display("FAIL hold_expiry: motion=%b stable=%b, required 0 1", state_motion, state_stable);
    else n_pass++;
  endtask

  task automatic test_glitch;
    int bad;
    bad = 0;
    for (int r = 0; r < 3; r++) begin
      motion_in = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (state_stable !== 1'b1 || state_motion !== 1'b0 || sseg_value !== 16'h0001) bad++;
      end
      motion_in = 1'b0;
      repeat (5) begin
        @(negedge clk);
        if (state_stable !== 1'b1 || state_motion !== 1'b0 || sseg_value !== 16'h0001) bad++;
      end
    end
    n_checks++;
    if (bad != 0) $display("FAIL glitch_ignored: %0d disturbed cycles, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_arm;
    int k, t;
    arm = 1'b0;
    k = edge_n + 1;
    motion_in = 1'b1;
    wait_edge(k + 10);
    n_checks++;
    if (state_stable !== 1'b1 || sseg_value !== 16'h0001)
      $display("FAIL disarmed_edge: stable=%b sseg=%h, required 1 0001", state_stable, sseg_value);
    else n_pass++;
    arm = 1'b1;
    wait_edge(k + 16);
    n_checks++;
    if (state_stable !== 1'b1 || sseg_value !== 16'h0001)
      $display("FAIL edge_not_remembered: stable=%b sseg=%h, required 1 0001", state_stable, sseg_value);
    else n_pass++;
    motion_in = 1'b0;
    wait_edge(edge_n + 8);
    k = edge_n + 1;
    motion_in = 1'b1;
    push_event(k + 6, 16'h0002);
    wait_edge(k + 6);
    t = edge_n + 1 + 6;
    motion_in = 1'b0;
    wait_edge(t + 1);
    arm = 1'b0;
    wait_edge(t + 2);
    n_checks++;
    if (state_stable !== 1'b1 || state_motion !== 1'b0)
      $display("FAIL arm_clear_in_hold: stable=%b motion=%b, required 1 0", state_stable, state_motion);
    else n_pass++;
    arm = 1'b1;
    wait_edge(edge_n + 4);
  endtask

  task automatic test_clear;
    int k;
    k = edge_n + 1;
    motion_in = 1'b1;
    push_event(k + 6, 16'h0000);
    wait_edge(k + 5);
    clear_count = 1'b1;
    wait_edge(k + 6);
    clear_count = 1'b0;
    n_checks++;
    if (sseg_value !== 16'h0000 || state_motion !== 1'b1)
      $display("FAIL clear_wins: sseg=%h motion=%b, required 0000 1", sseg_value, state_motion);
    else n_pass++;
    motion_in = 1'b0;
    wait_edge(k + 6 + 1 + 6 + H + 2);
    k = edge_n + 1;
    motion_in = 1'b1;
    push_event(k + 6, 16'h0001);
    wait_edge(k + 8);
    motion_in = 1'b0;
    wait_edge(k + 8 + 1 + 6 + H + 2);
  endtask

  task automatic test_reset_mid;
    int k;
    k = edge_n + 1;
    motion_in = 1'b1;
    push_event(k + 6, 16'h0002);
    wait_edge(k + 8);
    n_checks++;
    if (state_motion !== 1'b1) $display("FAIL pre_reset_motion: motion=%b, required 1", state_motion);
    else n_pass++;
    #2;
    reset = 1'b1;
    motion_in = 1'b0;
    #1;
    n_checks++;
    if ({warming, state_motion, state_stable, motion_pulse, sseg_value} !== {4'b1000, 16'h0000})
      $display("FAIL async_reset: w/m/s/p=%b%b%b%b sseg=%h, required 1000 0000",
               warming, state_motion, state_stable, motion_pulse, sseg_value);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_edge(W - 1);
    n_checks++;
    if (warming !== 1'b1) $display("FAIL rewarm_hold: warming=%b at edge %0d, required 1", warming, edge_n);
    else n_pass++;
    wait_edge(W);
    n_checks++;
    if (warming !== 1'b0 || state_stable !== 1'b1 || sseg_value !== 16'h0000)
      $display("FAIL rewarm_exit: warming=%b stable=%b sseg=%h, required 0 1 0000",
               warming, state_stable, sseg_value);
    else n_pass++;
  endtask

  task automatic test_saturate;
    @(negedge clk);
    for (int i = 1; i <= 10000; i++) begin
      fq.push_back(to_bcd(i));
      motion_f = 1'b1;
      repeat (2) @(negedge clk);
      motion_f = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (f_bad != 0 || fq.size() != 0)
      $display("FAIL sat_sequence: %0d bad, %0d missing, first sseg=%h required %h",
               f_bad, fq.size(), f_bad_act, f_bad_req);
    else n_pass++;
    n_checks++;
    if (f_pulses != 10000) $display("FAIL sat_pulse_count: %0d pulses, required 10000", f_pulses);
    else n_pass++;
    n_checks++;
    if ({f_last[0], f_last[1], f_last[2]} !== {16'h9998, 16'h9999, 16'h9999})
      $display("FAIL sat_boundary: last counts %h %h %h, required 9998 9999 9999", f_last[0], f_last[1], f_last[2]);
    else n_pass++;
    n_checks++;
    if (sseg_f !== 16'h9999 || ss_f !== 1'b1 || sm_f !== 1'b0 || warm_f !== 1'b0)
      $display("FAIL sat_final: sseg=%h stable=%b motion=%b warming=%b, required 9999 1 0 0",
               sseg_f, ss_f, sm_f, warm_f);
    else n_pass++;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: run exceeded time limit at edge %0d", edge_n);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_detect();
    test_retrigger();
    test_glitch();
    test_arm();
    test_clear();
    test_reset_mid();
    test_saturate();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drained: %0d events outstanding, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/motion_event_ctrl.md
# motion_event_ctrl

Sequencing controller for the PIR motion sensor path. It synchronizes and debounces the raw Pmod sensor line and masks the sensor's power-up warm-up period. It runs the detection state machine (idle / motion / hold-off with retrigger) and keeps a saturating 4-digit BCD event count. Its outputs drive the two status LEDs and the 16-bit value for the seven-segment display controller, replacing the raw sensor-to-LED path in the top level.

## Interface

- WARMUP_CYCLES, 100_000_000: cycles after reset during which sensor input is ignored.
- DEBOUNCE_CYCLES, 1_000_000: consecutive cycles the synchronized input must hold a new level before the filtered level changes (≥1).
- HOLD_CYCLES, 200_000_000: hold-off length after motion ends; a retrigger inside it does not count (≥1).
- clk  input  1  100 MHz system clock.
- reset  input  1  Asynchronous, active-high reset.
- motion_in  input  1  Raw sensor line (JA1), asynchronous to clk.
- arm  input  1  Level; 1 enables event detection.
- clear_count  input  1  Synchronous pulse; clears the event count.
- state_motion  output  1  High in MOTION and HOLD (led[0]).
- state_stable  output  1  High in IDLE (led[1]).
- warming  output  1  High in WARMUP.
- motion_pulse  output  1  One-cycle strobe per counted event.
- sseg_value  output  16  BCD event count, 4 digits, [15:12] = thousands.

## Operation

- Input path: 2-flop synchronizer, then debouncer. The debouncer keeps a filtered level plus a stability counter. The counter resets whenever the synchronized value equals the filtered level. The filtered level takes the new value on the cycle the counter reaches DEBOUNCE_CYCLES. Rising-edge detect runs on the filtered level.
- States: WARMUP, IDLE, MOTION, HOLD.
- WARMUP: counts cycles and ignores the input. After WARMUP_CYCLES cycles it goes to IDLE. A filtered level already high on entry to IDLE does not create an event; only a later rising edge does.
- IDLE: on a filtered rising edge with arm=1, go to MOTION, pulse motion_pulse and increment the count. Edges with arm=0 are discarded and not remembered.
- MOTION: stays while the filtered level is high. A filtered fall moves to HOLD and loads the hold counter.
- HOLD: a filtered rise moves back to MOTION with no count and no pulse (retrigger). After HOLD_CYCLES cycles it returns to IDLE.
- arm=0 in MOTION or HOLD forces IDLE on the next edge.
- Count: 4-digit BCD with per-digit carry. It saturates at 9999; a further event still pulses motion_pulse but the count holds.
- clear_count sets the count to 0000 on the next edge. If clear and increment coincide, clear wins.
- Counter widths are $clog2(param+1) bits. There is no wrap anywhere.
- Reset mid-operation: all state is lost and the block restarts WARMUP. The synchronizer, debouncer and count are cleared.

## Timing

- Reset values: state=WARMUP, warming=1, state_motion=0, state_stable=0, motion_pulse=0, sseg_value=16'h0000, filtered level=0.
- All outputs are registered and change only on rising clk edges (or on reset assertion).
- Input latency: motion_in changes before edge k and holds. The synchronized value changes at edge k+1. The filtered level changes at edge k+1+DEBOUNCE_CYCLES.
- state_motion, motion_pulse and the sseg_value increment appear at edge k+2+DEBOUNCE_CYCLES.
- Glitches shorter than DEBOUNCE_CYCLES synchronized cycles have no effect.
- Reset deasserted before edge 0: warming drops and state_stable rises at edge WARMUP_CYCLES.
- HOLD entered at edge t: returns to IDLE at edge t+HOLD_CYCLES unless a retrigger occurs. At that point state_motion falls and state_stable rises.
- motion_pulse is exactly one cycle wide. Only one event is possible per IDLE→MOTION transition.

## Test plan

All scenarios use WARMUP_CYCLES=20, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.

- Reset, motion_in=1 throughout, arm=1 -> warming=1 for edges 0–19; state_stable=1 from edge 20; no motion_pulse; sseg_value stays 0000.
- After warm-up, arm=1, motion_in rises before edge k and is held -> motion_pulse high only at edge k+6; state_motion=1; sseg_value=0001.
- Pulses of 3 cycles on motion_in -> no filtered change, no state change, count unchanged.
- Motion falls (HOLD entered at edge t) and rises again so the filtered rise lands at t+5 -> back to MOTION, no pulse, count unchanged. After the final fall, IDLE at hold entry +10.
- arm=0 during a rising edge -> no event. arm cleared while in HOLD -> IDLE next edge. Count preset near 9999 via repeated events -> 9998 → 9999 → 9999 with pulse still issued. clear_count coincident with an event -> 0000.
- Assert reset while in MOTION -> all outputs reach reset values immediately (asynchronously) and WARMUP restarts from 0.
